// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register map, timer types
// and the byte-lane merge used by every 32-bit half write.
package clint_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMER_W = 64;
  localparam int unsigned BE_W    = XLEN / 8;

  typedef logic [TIMER_W-1:0] timer_t;

  localparam logic [XLEN-1:0] CLINT_MSIP        = 32'h0000_0000;
  localparam logic [XLEN-1:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
  localparam logic [XLEN-1:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
  localparam logic [XLEN-1:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
  localparam logic [XLEN-1:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

  // All ones keeps mtip low out of reset regardless of mtime.
  localparam timer_t MTIMECMP_RST = {TIMER_W{1'b1}};

  // Decoded write request handed from the bus front end to the timer.
  typedef struct packed {
    logic            mtime_lo;
    logic            mtime_hi;
    logic            cmp_lo;
    logic            cmp_hi;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] data;
  } timer_wr_t;

  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] data,
                                                 input logic [BE_W-1:0] be);
    logic [XLEN-1:0] res;
    res = old;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_if.sv
// SRAM-style responder port between the arbiter and the CLINT.
interface clint_if;
  import clint_pkg::*;

  logic            cs;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] di;
  logic [XLEN-1:0] dout;
  logic            busy;
  logic            err;

  modport master (output cs, we, addr, be, di, input dout, busy, err);
  modport slave  (input cs, we, addr, be, di, output dout, busy, err);

endinterface

// File: rtl/clint_timer.sv
// Prescaler, 64-bit mtime counter, mtimecmp register and registered mtip compare.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic      clk,
  input  logic      rstn,
  input  timer_wr_t wr,
  output timer_t    mtime,
  output timer_t    mtimecmp,
  output logic      mtip
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;
  logic [PS_W-1:0] ps_cnt_nxt;
  logic            tick;
  timer_t          mtime_nxt;
  timer_t          cmp_nxt;

  // Free-running prescaler, unaffected by bus traffic.
  always_comb begin
    tick       = (ps_cnt == PS_LAST);
    ps_cnt_nxt = tick ? '0 : ps_cnt + PS_W'(1);
  end

  // A write to either half suppresses the increment for that cycle entirely.
  always_comb begin
    mtime_nxt = mtime;
    if (wr.mtime_lo || wr.mtime_hi) begin
      if (wr.mtime_lo) mtime_nxt[XLEN-1:0]       = byte_merge(mtime[XLEN-1:0], wr.data, wr.be);
      if (wr.mtime_hi) mtime_nxt[TIMER_W-1:XLEN] = byte_merge(mtime[TIMER_W-1:XLEN], wr.data, wr.be);
    end else if (tick) begin
      mtime_nxt = mtime + TIMER_W'(1);
    end
  end

  always_comb begin
    cmp_nxt = mtimecmp;
    if (wr.cmp_lo) cmp_nxt[XLEN-1:0]       = byte_merge(mtimecmp[XLEN-1:0], wr.data, wr.be);
    if (wr.cmp_hi) cmp_nxt[TIMER_W-1:XLEN] = byte_merge(mtimecmp[TIMER_W-1:XLEN], wr.data, wr.be);
  end

  // mtip compares next-state values so it tracks the same edge as the update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ps_cnt   <= '0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      mtip     <= 1'b0;
    end else begin
      ps_cnt   <= ps_cnt_nxt;
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      mtip     <= (mtime_nxt >= cmp_nxt);
    end
  end

endmodule

// File: rtl/clint_slv.sv
// Core-local interruptor responder: address decode, read mux, msip and err,
// with the timer datapath in clint_timer.
module clint_slv
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic     clk,
  input  logic     rstn,
  clint_if.slave   bus,
  output logic     msip,
  output logic     mtip
);

  logic [ADDR_W-3:0] word;
  logic              sel_msip;
  logic              sel_cmp_lo;
  logic              sel_cmp_hi;
  logic              sel_mt_lo;
  logic              sel_mt_hi;
  logic              mapped;
  logic              wr_en;
  logic [XLEN-1:0]   rd_val;
  logic [XLEN-1:0]   dout_q;
  logic              err_q;
  logic              msip_q;
  timer_wr_t         tw;
  timer_t            mtime;
  timer_t            mtimecmp;
  logic              unused_addr_bits;

  // Upper address bits were already consumed by the arbiter.
  assign unused_addr_bits = ^{bus.addr[XLEN-1:ADDR_W], bus.addr[1:0]};

  assign word       = bus.addr[ADDR_W-1:2];
  assign sel_msip   = (word == CLINT_MSIP[ADDR_W-1:2]);
  assign sel_cmp_lo = (word == CLINT_MTIMECMP_LO[ADDR_W-1:2]);
  assign sel_cmp_hi = (word == CLINT_MTIMECMP_HI[ADDR_W-1:2]);
  assign sel_mt_lo  = (word == CLINT_MTIME_LO[ADDR_W-1:2]);
  assign sel_mt_hi  = (word == CLINT_MTIME_HI[ADDR_W-1:2]);
  assign mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
  assign wr_en      = bus.cs & bus.we;

  // Unmapped reads return zero.
  always_comb begin
    rd_val = '0;
    if (sel_msip)        rd_val = {{(XLEN-1){1'b0}}, msip_q};
    else if (sel_cmp_lo) rd_val = mtimecmp[XLEN-1:0];
    else if (sel_cmp_hi) rd_val = mtimecmp[TIMER_W-1:XLEN];
    else if (sel_mt_lo)  rd_val = mtime[XLEN-1:0];
    else if (sel_mt_hi)  rd_val = mtime[TIMER_W-1:XLEN];
  end

  always_comb begin
    tw          = '0;
    tw.be       = bus.be;
    tw.data     = bus.di;
    tw.mtime_lo = wr_en & sel_mt_lo;
    tw.mtime_hi = wr_en & sel_mt_hi;
    tw.cmp_lo   = wr_en & sel_cmp_lo;
    tw.cmp_hi   = wr_en & sel_cmp_hi;
  end

  // dout holds between reads like the sram macros.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= '0;
      err_q  <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      err_q <= bus.cs & ~mapped;
      if (bus.cs && !bus.we) dout_q <= rd_val;
      if (wr_en && sel_msip && bus.be[0]) msip_q <= bus.di[0];
    end
  end

  clint_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .wr       (tw),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

  assign bus.dout = dout_q;
  assign bus.err  = err_q;
  assign bus.busy = 1'b0;
  assign msip     = msip_q;

endmodule

// File: doc/clint_slv.md
Name: clint_slv

Overview:
- Memory-mapped core-local interruptor (machine timer + software interrupt), one hart.
- Responder on the arbiter master-side SRAM-style port: cs/we/addr/byte/di/do/busy, same timing as the on-chip sram macros.
- Drives the cpu_top msip/mtip inputs, which are tied off today.
- Holds a 64-bit mtime counter, a 64-bit mtimecmp register and a 1-bit msip register.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment (>=1).
- ADDR_W, 16, number of low address bits decoded. Upper bits are ignored; the arbiter already selected this port.

Ports:
- clk      input   1   core clock
- rstn     input   1   asynchronous active-low reset
- cs       input   1   access request, sampled at posedge clk
- we       input   1   1 = write, 0 = read
- addr     input   32  byte address; [1:0] ignored
- byte     input   4   byte strobes for writes
- di       input   32  write data
- do       output  32  read data, registered
- busy     output  1   always 0 (zero wait states)
- err      output  1   one-cycle pulse on an unmapped access
- msip     output  1   software interrupt pending
- mtip     output  1   timer interrupt pending, registered

Behaviour:
- Reset values (async, rstn low):
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - msip = 0, mtip = 0, do = 0, err = 0
  - prescale counter = 0
- Register map, decoded on addr[ADDR_W-1:2]:
  - 0x0000: msip, bit0 only; other bits read 0
  - 0x4000: mtimecmp[31:0]
  - 0x4004: mtimecmp[63:32]
  - 0xBFF8: mtime[31:0]
  - 0xBFFC: mtime[63:32]
- Read: cs=1, we=0 at edge N -> do holds the register value sampled at edge N, valid after edge N through edge N+1.
- do holds its last value whenever there is no read, matching sram behaviour.
- Write: cs=1, we=1 at edge N -> each byte with byte[i]=1 is updated at edge N and visible from cycle N+1.
  - msip is written only when byte[0]=1 (takes di[0]).
  - do is unchanged by a write.
- Unmapped address: a read returns do=0, a write is ignored; err=1 for exactly one cycle after edge N.
- Prescaler:
  - The counter counts 0..PRESCALE-1.
  - A tick fires when it equals PRESCALE-1; the counter then wraps to 0.
  - With PRESCALE=1 the tick fires every cycle.
- mtime increments by 1 on each tick with full 64-bit carry; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write vs increment in the same cycle:
  - The written bytes take di.
  - The unwritten bytes of that 32-bit half keep their pre-increment value.
  - The other half is not incremented that cycle. The write fully wins for that cycle, with no carry into or out of it.
- Read vs increment in the same cycle: the read returns the pre-increment value.
- mtip is registered: mtip <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare. It is therefore updated the same edge as any mtime/mtimecmp change and is visible one cycle after the write or tick.
- msip output = msip register.
- busy is constant 0; the arbiter never stalls on this port.
- Reset mid-operation clears all state immediately. The first access after rstn rises behaves as from reset.

Decomposition:
- Shared package cpu_define / clint_pkg holds:
  - the register offsets (CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI)
  - the mtimecmp reset value
  - a typedef for the 64-bit timer value
- One natural sub-module: clint_timer. It contains the prescaler, mtime counter, byte-masked write merge and mtip compare register. The top handles address decode, the read mux and err.

Test Plan:
- Reset: after rstn release, read 0xBFF8 at the first edge -> do=0. msip=0, mtip=0, busy=0 throughout.
- Timer fire:
  - Setup: PRESCALE=1; write 0x4004=0, then 0x4000=0x20; mtime starts counting from 0.
  - Required: mtip rises in the cycle after mtime reaches 0x20, and stays high.
  - Then write 0x4004=0xFFFF_FFFF -> mtip=0 in the next cycle.
- Byte strobes and msip:
  - Write 0x4000, di=0xAABBCCDD, byte=4'b0101 after reset -> read 0x4000 returns 0xFFBBFFDD.
  - Write 0x0000, di=1, byte=4'b0001 -> msip=1.
  - Write 0x0000, di=1, byte=4'b0010 -> msip unchanged.
- Carry and collision:
  - Write mtime lo=0xFFFF_FFFF, hi=0 -> after one tick, hi reads 1 and lo reads 0.
  - Write lo=5 on the same cycle as a tick -> lo reads 5, hi unchanged.
- Prescale: PRESCALE=4, with mtime at 0 -> after 12 cycles mtime=3, and the prescaler phase is continuous across reads.
- Unmapped: read 0x1234 -> do=0, err high for one cycle. Write 0x1234 -> no register changes, err pulses. A following read of 0x4000 returns the correct value.
